pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 sysclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand set presented this cycle.
REQ-005 in_ready  output  1  block accepts operand set this cycle.
REQ-006 op  input  3  operation code (see REQ-012).
REQ-007 numa  input  WIDTH  operand A.
REQ-008 numb  input  WIDTH  operand B (ignored by INC, DEC and unary ops).
REQ-009 out_valid  output  1  result presented this cycle.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 outa  output  WIDTH  result; flags  output  4  {N,V,C,Z}, bit 3 = N.

Function
REQ-012 Op encoding SHALL be: 0 ADD a+b; 1 SUB a-b; 2 INC a+1; 3 DEC a-1; 4 AND; 5 OR; 6 XOR; 7 SHL a<<b[log2(WIDTH)-1:0], zero-fill.
REQ-013 Transfer SHALL occur on a cycle where valid and ready are both high on the same side; no transfer otherwise.
REQ-014 Pipeline SHALL be two register stages: S1 captures op/operands, S2 holds computed result and flags; latency in->out SHALL be exactly 2 cycles when out_ready is held high.
REQ-015 Throughput SHALL be one transfer per cycle with out_ready high; no bubbles inserted.
REQ-016 A stage SHALL advance when it is empty or its content moves downstream in the same cycle; in_ready = !S1_valid | S1_advance.
REQ-017 With out_ready low, S2 SHALL hold outa/flags stable and out_valid high; S1 SHALL fill, then in_ready SHALL drop; no transfer lost or duplicated.
REQ-018 Arithmetic SHALL be computed at WIDTH+1 bits; outa = low WIDTH bits; wrap-around modulo 2^WIDTH (e.g. INC of all-ones -> 0).
REQ-019 C: ADD/INC carry-out; SUB/DEC borrow (1 when a < subtrahend unsigned); logic ops and SHL C = last bit shifted out (0 for shift 0, and for AND/OR/XOR).
REQ-020 V: signed overflow for ADD/SUB/INC/DEC; 0 for all other ops.
REQ-021 Z = (outa == 0); N = outa[WIDTH-1], for every op.
REQ-022 Simultaneous input accept and output drain SHALL both complete in the same cycle.
REQ-023 outa/flags SHALL be don't-care while out_valid is low, but SHALL NOT change while out_valid is high and out_ready is low.

Reset
REQ-024 On rst high at a sysclk edge: S1_valid, S2_valid, out_valid SHALL be 0; outa SHALL be 0; flags SHALL be 0.
REQ-025 in_ready SHALL be 0 while rst is high, and 1 on the first cycle after rst is released.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight transfers; none emerge after release.

Structure
REQ-027 Op codes (typedef alu_op_t) and flag bit indices SHALL reside in shared package alu_pkg.
REQ-028 Combinational compute SHALL be sub-module alu_core (op, a, b -> result, flags), instantiated between S1 and S2.
REQ-029 Handshake/pipeline registers SHALL reside in pipe_alu only; no latches, single clock domain.

Verification (WIDTH=8)
REQ-030 Reset then ADD 0x7F+0x01, out_ready=1 -> 2 cycles later outa=0x80, flags N=1 V=1 C=0 Z=0.
REQ-031 INC 0xFF -> outa=0x00, Z=1 C=1 V=0; SUB 0x00-0x01 -> outa=0xFF, N=1 C=1 V=0.
REQ-032 Back-to-back 8 ops (one per op code) with out_ready=1 -> 8 results on consecutive cycles, in order, first at cycle 2.
REQ-033 out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts; outa stable; on release, both results drain in order, no loss or duplicate.
REQ-034 SHL 0x81 by 1 -> outa=0x02, C=1; XOR 0xAA^0xAA -> outa=0x00, Z=1, C=0.
REQ-035 rst pulsed with two items in flight -> out_valid=0 after reset edge; no stale result appears afterward.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared op codes and flag bit positions for the pipelined ALU.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_INC = 3'd2,
      OP_DEC = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_XOR = 3'd6,
      OP_SHL = 3'd7
   } alu_op_t;

   localparam int c_flag_n = 3;
   localparam int c_flag_v = 2;
   localparam int c_flag_c = 1;
   localparam int c_flag_z = 0;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_core                                                             |
// | Combinational ALU: op, a, b -> result and {N,V,C,Z} flags.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  alu_op_t            i_op,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [WIDTH-1:0]   o_result,
   output logic [3:0]         o_flags
);

   localparam int               c_shw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH:0]   c_one = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0]   w_ext_a;
   logic [WIDTH:0]   w_ext_b;
   logic [WIDTH:0]   w_wide;
   logic [c_shw-1:0] w_shamt;
   logic             w_v;

   assign w_ext_a = {1'b0, i_a};
   assign w_ext_b = {1'b0, i_b};
   assign w_shamt = i_b[c_shw-1:0];

   // Bit WIDTH of the extended result is carry, borrow, or the last bit shifted out.
   always_comb begin
      w_wide = '0;
      w_v    = 1'b0;
      case (i_op)
         OP_ADD: begin
            w_wide = w_ext_a + w_ext_b;
            w_v    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_wide[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_wide = w_ext_a - w_ext_b;
            w_v    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_wide[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_INC: begin
            w_wide = w_ext_a + c_one;
            w_v    = !i_a[WIDTH-1] && w_wide[WIDTH-1];
         end
         OP_DEC: begin
            w_wide = w_ext_a - c_one;
            w_v    = i_a[WIDTH-1] && !w_wide[WIDTH-1];
         end
         OP_AND:  w_wide = {1'b0, i_a & i_b};
         OP_OR:   w_wide = {1'b0, i_a | i_b};
         OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
         OP_SHL:  w_wide = w_ext_a << w_shamt;
         default: w_wide = '0;
      endcase
   end

   assign o_result = w_wide[WIDTH-1:0];

   always_comb begin
      o_flags           = '0;
      o_flags[c_flag_n] = w_wide[WIDTH-1];
      o_flags[c_flag_v] = w_v;
      o_flags[c_flag_c] = w_wide[WIDTH];
      o_flags[c_flag_z] = (w_wide[WIDTH-1:0] == '0);
   end

endmodule
`default_nettype wire

// File: rtl/pipe_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_alu                                                             |
// | Two-stage valid/ready ALU pipeline: S1 operands, S2 result + flags.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               sysclk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   numa,
   input  logic [WIDTH-1:0]   numb,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   outa,
   output logic [3:0]         flags
);

   logic             r_s1_valid;
   alu_op_t          r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_outa;
   logic [3:0]       r_flags;

   logic             w_s2_load;
   logic [WIDTH-1:0] w_result;
   logic [3:0]       w_flags;

   // S2 can take new data when empty or being drained this cycle; S1 likewise via S2.
   assign w_s2_load = !r_s2_valid || out_ready;
   assign in_ready  = !rst && (!r_s1_valid || w_s2_load);

   alu_core #(
      .WIDTH    (WIDTH)
   ) u_core (
      .i_op     (r_s1_op),
      .i_a      (r_s1_a),
      .i_b      (r_s1_b),
      .o_result (w_result),
      .o_flags  (w_flags)
   );

   always_ff @(posedge sysclk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= OP_ADD;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s2_valid <= 1'b0;
         r_outa     <= '0;
         r_flags    <= '0;
      end else begin
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_outa  <= w_result;
               r_flags <= w_flags;
            end
         end
         if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1_op <= alu_op_t'(op);
               r_s1_a  <= numa;
               r_s1_b  <= numb;
            end
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign outa      = r_outa;
   assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_pipe_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_alu                                                          |
// | Scoreboard bench for pipe_alu (WIDTH=8) against an arithmetic model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_alu;

   logic       sysclk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [7:0] numa;
   logic [7:0] numb;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] outa;
   logic [3:0] flags;

   typedef struct {
      logic [7:0] r;
      logic [3:0] f;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   bit         lat_chk = 1'b0;
   bit         rand_done = 1'b0;
   bit         held = 1'b0;
   logic [7:0] h_outa;
   logic [3:0] h_flags;

   pipe_alu #(.WIDTH(8)) dut (
      .sysclk    (sysclk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .numa      (numa),
      .numb      (numb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outa      (outa),
      .flags     (flags)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: returns {N,V,C,Z, result} from plain integer arithmetic.
   function automatic logic [11:0] model(input int o, input int a, input int b);
      int r, sa, sb, sr, sh;
      bit c, v;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      r = 0; sr = 0; c = 1'b0; v = 1'b0;
      case (o)
         0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
         1: begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127) || (sr < -128); end
         2: begin r = a + 1; c = (r > 255); sr = sa + 1;  v = (sr > 127); end
         3: begin r = a - 1; c = (a == 0);  sr = sa - 1;  v = (sr < -128); end
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         default: begin
            sh = b % 8;
            r  = a << sh;
            c  = (sh == 0) ? 1'b0 : (((a >> (8 - sh)) & 1) != 0);
         end
      endcase
      r = r & 255;
      return {r[7], v, c, (r == 0), r[7:0]};
   endfunction

   task automatic send(input int o, input int a, input int b, input bit use_exp,
                       input logic [11:0] expv);
      exp_t       e;
      int         n;
      logic [11:0] m;
      op = 3'(o); numa = 8'(a); numb = 8'(b); in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge sysclk);
         n++;
      end while (!in_ready && n < 64);
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
      end else begin
         m = use_exp ? expv : model(o, a, b);
         e.r = m[7:0]; e.f = m[11:8]; e.cyc = cyc;
         q.push_back(e);
         if (lat_chk) chk("in_ready_no_bubble", n, 1);
      end
      @(posedge sysclk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge sysclk);
         n++;
      end
      chk("drain_pending", q.size(), 0);
   endtask

   // Output monitor: pops on every output transfer and checks hold while stalled.
   always @(negedge sysclk) begin
      if (rst) begin
         q.delete();
         held = 1'b0;
      end else if (out_valid) begin
         if (held) begin
            chk("hold_outa", outa, h_outa);
            chk("hold_flags", flags, h_flags);
         end
         if (out_ready) begin
            held = 1'b0;
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: got outa=%0h flags=%0h, required no output", outa, flags);
            end else begin
               mon_e = q.pop_front();
               chk("outa", outa, mon_e.r);
               chk("flags", flags, mon_e.f);
               if (lat_chk) chk("latency", cyc - mon_e.cyc, 2);
            end
         end else begin
            held = 1'b1;
            h_outa = outa;
            h_flags = flags;
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      int acc;
      int a;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; numa = '0; numb = '0;

      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outa", outa, 0);
      chk("rst_flags", flags, 0);
      @(posedge sysclk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge sysclk);
      chk("in_ready_after_rst", in_ready, 1);
      @(posedge sysclk); #1;

      // Directed corner cases with hand-derived results, full-rate output.
      lat_chk = 1'b1;
      send(0, 8'h7F, 8'h01, 1'b1, {4'b1100, 8'h80});
      send(2, 8'hFF, 8'h00, 1'b1, {4'b0011, 8'h00});
      send(1, 8'h00, 8'h01, 1'b1, {4'b1010, 8'hFF});
      send(7, 8'h81, 8'h01, 1'b1, {4'b0010, 8'h02});
      send(6, 8'hAA, 8'hAA, 1'b1, {4'b0001, 8'h00});
      // One of each op back to back: a=0x3C, b=0x05.
      send(0, 8'h3C, 8'h05, 1'b1, {4'b0000, 8'h41});
      send(1, 8'h3C, 8'h05, 1'b1, {4'b0000, 8'h37});
      send(2, 8'h3C, 8'h05, 1'b1, {4'b0000, 8'h3D});
      send(3, 8'h3C, 8'h05, 1'b1, {4'b0000, 8'h3B});
      send(4, 8'h3C, 8'h05, 1'b1, {4'b0000, 8'h04});
      send(5, 8'h3C, 8'h05, 1'b1, {4'b0000, 8'h3D});
      send(6, 8'h3C, 8'h05, 1'b1, {4'b0000, 8'h39});
      send(7, 8'h3C, 8'h05, 1'b1, {4'b1010, 8'h80});
      send(3, 8'h80, 8'h00, 1'b1, {4'b0100, 8'h7F});
      drain();
      lat_chk = 1'b0;

      // Backpressure: only two items fit while the consumer stalls.
      @(posedge sysclk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd0; numa = 8'h10; numb = 8'h22;
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge sysclk);
         if (in_ready) begin
            mon_e.r = model(0, numa, numb) & 12'h0FF;
            q.push_back('{r: model(0, numa, numb) & 8'hFF, f: model(0, numa, numb) >> 8, cyc: cyc});
            acc++;
            @(posedge sysclk); #1;
            numa = numa + 8'h11;
         end else begin
            @(posedge sysclk); #1;
         end
      end
      in_valid = 1'b0;
      chk("stall_accepts", acc, 2);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      out_ready = 1'b1;
      drain();

      // Reset with two items in flight: nothing may emerge afterwards.
      @(posedge sysclk); #1;
      out_ready = 1'b0;
      send(0, 8'h01, 8'h02, 1'b0, 12'h0);
      send(6, 8'h0F, 8'hF0, 1'b0, 12'h0);
      rst = 1'b1;
      @(posedge sysclk);
      @(negedge sysclk);
      chk("flush_out_valid", out_valid, 0);
      @(posedge sysclk); #1;
      rst = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge sysclk);
      #1;
      chk("flush_no_output", out_valid, 0);

      // Randomized traffic with random gaps and random consumer stalls.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge sysclk); #1; end
               case ($urandom_range(0, 3))
                  0:       a = 8'h7F;
                  1:       a = 8'hFF;
                  default: a = $urandom_range(0, 255);
               endcase
               send($urandom_range(0, 7), a, $urandom_range(0, 255), 1'b0, 12'h0);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge sysclk); #1;
               out_ready = ($urandom_range(0, 9) < 7);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
